// File: rtl/io_port_bank.sv
// Memory-mapped I/O responder: GPIO, free-running timer with compare, and a
// small TX FIFO feeding an 8N1 UART transmitter, with one level interrupt.
module io_port_bank #(
  parameter int GPIO_WIDTH     = 8,
  parameter int FIFO_DEPTH_LOG = 2,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [7:0]            io_addr,
  input  logic                  io_en,
  input  logic                  io_we,
  input  logic [31:0]           io_data_write,
  output logic [31:0]           io_data_read,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  uart_tx,
  output logic                  irq
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [5:0] A_GPIO_OUT = 6'h00;
  localparam logic [5:0] A_GPIO_IN  = 6'h01;
  localparam logic [5:0] A_COUNT    = 6'h02;
  localparam logic [5:0] A_CMP      = 6'h03;
  localparam logic [5:0] A_CTRL     = 6'h04;
  localparam logic [5:0] A_STATUS   = 6'h05;
  localparam logic [5:0] A_TX_DATA  = 6'h06;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [GPIO_WIDTH-1:0]   r_gpio_out;
  logic [GPIO_WIDTH-1:0]   r_sync1;
  logic [GPIO_WIDTH-1:0]   r_sync2;
  logic [31:0]             r_count;
  logic [31:0]             r_cmp;
  logic [2:0]              r_ctrl;
  logic                    r_match;
  logic                    r_ovf;
  logic [7:0]              r_fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG:0] r_fifo_cnt;
  uart_state_t             r_state;
  logic [BAUD_W-1:0]       r_baud;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shift;
  logic                    r_tx;

  logic [5:0]  w_sel;
  logic        w_wr;
  logic        w_wr_status;
  logic        w_push_req;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_busy;
  logic [31:0] w_status;
  logic [1:0]  w_unused_addr;

  assign w_sel         = io_addr[7:2];
  assign w_unused_addr = io_addr[1:0];
  assign w_wr          = io_en & io_we;
  assign w_wr_status   = w_wr && (w_sel == A_STATUS);
  assign w_push_req    = w_wr && (w_sel == A_TX_DATA);

  assign w_full  = (r_fifo_cnt == (FIFO_DEPTH_LOG + 1)'(DEPTH));
  assign w_empty = (r_fifo_cnt == '0);
  assign w_busy  = (r_state != S_IDLE);
  // Full is judged before the edge, so a pop in the same cycle cannot rescue a push.
  assign w_push  = w_push_req & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;

  assign w_status = {16'd0, 8'(r_fifo_cnt), 3'd0, r_ovf, w_busy, w_empty, w_full, r_match};

  always_comb begin
    io_data_read = '0;
    if (io_en) begin
      case (w_sel)
        A_GPIO_OUT: io_data_read = 32'(r_gpio_out);
        A_GPIO_IN:  io_data_read = 32'(r_sync2);
        A_COUNT:    io_data_read = r_count;
        A_CMP:      io_data_read = r_cmp;
        A_CTRL:     io_data_read = {29'd0, r_ctrl};
        A_STATUS:   io_data_read = w_status;
        default:    io_data_read = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_cmp      <= '0;
      r_ctrl     <= '0;
      r_match    <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_wr && (w_sel == A_GPIO_OUT)) r_gpio_out <= io_data_write[GPIO_WIDTH-1:0];
      if (w_wr && (w_sel == A_COUNT)) begin
        r_count <= io_data_write;
      end else if (r_ctrl[0]) begin
        r_count <= r_count + 32'd1;
      end
      if (w_wr && (w_sel == A_CMP))  r_cmp  <= io_data_write;
      if (w_wr && (w_sel == A_CTRL)) r_ctrl <= io_data_write[2:0];
      // Clear first so a coincident match set overrides the W1C.
      if (w_wr_status && io_data_write[0]) r_match <= 1'b0;
      if (r_ctrl[0] && (r_count == r_cmp)) r_match <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= io_data_write[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (FIFO_DEPTH_LOG + 1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (FIFO_DEPTH_LOG + 1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_wr_status && io_data_write[4]) r_ovf <= 1'b0;
      if (w_push_req && w_full) r_ovf <= 1'b1;
    end
  end

  // The shifter doubles as the registered read port of the FIFO memory.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_fifo_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_baud  <= BAUD_RELOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_baud == '0) begin
            r_baud    <= BAUD_RELOAD;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (r_baud == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gpio_out = r_gpio_out;
  assign uart_tx  = r_tx;
  assign irq      = (r_match & r_ctrl[1]) | (w_empty & ~w_busy & r_ctrl[2]);

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: register access, timer, FIFO/UART
// framing via an expected-byte scoreboard, and reset mid-frame.
module tb_io_port_bank;

  localparam int CPB   = 4;
  localparam int GPIOW = 8;

  logic             clk = 1'b0;
  logic             resetb;
  logic [7:0]       io_addr;
  logic             io_en;
  logic             io_we;
  logic [31:0]      io_data_write;
  logic [31:0]      io_data_read;
  logic [GPIOW-1:0] gpio_in;
  logic [GPIOW-1:0] gpio_out;
  logic             uart_tx;
  logic             irq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          frames = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_data;

  io_port_bank #(.GPIO_WIDTH(GPIOW), .FIFO_DEPTH_LOG(2), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
    @(posedge clk);
    #1;
    io_en = 1'b0; io_we = 1'b0;
    $display("wr  %02h <= %08h", a, d);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    #1 d = io_data_read;
    @(posedge clk);
    #1;
    io_en = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] b, input bit accept);
    bus_wr(8'h18, {24'd0, b});
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames < n; i++) @(posedge clk);
    chk("frame_count", 64'(frames), 64'(n));
  endtask

  // Captures each frame plus the following idle cycle and scores it.
  initial begin : uart_mon
    logic [40:0] wave;
    logic [40:0] exp_wave;
    logic [7:0]  b;
    int          start_cyc;
    int          prev_start;
    bit          prev_pending;
    bit          aborted;
    prev_pending = 1'b0;
    prev_start   = 0;
    forever begin
      @(negedge clk);
      if (resetb === 1'b1 && uart_tx === 1'b0) begin
        start_cyc = cyc;
        wave      = '1;
        wave[0]   = 1'b0;
        aborted   = 1'b0;
        for (int i = 1; i < 41; i++) begin
          @(negedge clk);
          if (resetb !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          wave[i] = uart_tx;
        end
        if (aborted) begin
          prev_pending = 1'b0;
          $display("uart frame aborted by reset");
        end else if (exp_q.size() == 0) begin
          chk("frame_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          b = exp_q.pop_front();
          for (int i = 0; i < 41; i++)
            exp_wave[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
          chk("frame_wave", 64'(wave), 64'(exp_wave));
          if (prev_pending) chk("frame_gap", 64'(start_cyc - prev_start), 64'd41);
          prev_pending = (exp_q.size() > 0);
          prev_start   = start_cyc;
          frames++;
          $display("uart frame %0d byte %02h", frames, b);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    bit   busy_all;
    bit   line_low;
    int   f0;
    resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", 64'(gpio_out), 64'h0);
    chk("rst_uart_tx", 64'(uart_tx), 64'h1);
    chk("rst_irq", 64'(irq), 64'h0);
    @(negedge clk) resetb = 1'b1;
    bus_rd(8'h14, rd_data); chk("rst_status", 64'(rd_data), 64'h4);
    bus_rd(8'h08, rd_data); chk("rst_count", 64'(rd_data), 64'h0);
    @(negedge clk) io_addr = 8'h14;
    #1 chk("rd_disabled_zero", 64'(io_data_read), 64'h0);

    // GPIO and decode
    bus_wr(8'h00, 32'h0000_00A5);
    chk("gpio_out_a5", 64'(gpio_out), 64'hA5);
    bus_wr(8'h00, 32'hFFFF_FF5A);
    bus_rd(8'h00, rd_data); chk("gpio_out_rd", 64'(rd_data), 64'h5A);
    bus_wr(8'h1C, 32'hFFFF_FFFF);
    bus_rd(8'h1C, rd_data); chk("unmapped_rd", 64'(rd_data), 64'h0);
    bus_rd(8'h03, rd_data); chk("addr_lsb_ignored", 64'(rd_data), 64'h5A);
    @(negedge clk) gpio_in = 8'h3C;
    @(posedge clk);
    bus_rd(8'h04, rd_data); chk("gpio_in_latency", 64'(rd_data), 64'h0);
    bus_rd(8'h04, rd_data); chk("gpio_in_sync", 64'(rd_data), 64'h3C);
    bus_rd(8'h40, rd_data); chk("rd_0x40", 64'(rd_data), 64'h0);
    bus_rd(8'h18, rd_data); chk("rd_tx_data", 64'(rd_data), 64'h0);

    // Timer compare, match irq, W1C
    bus_wr(8'h0C, 32'd5);
    bus_wr(8'h08, 32'd0);
    bus_wr(8'h10, 32'h3);
    repeat (5) @(posedge clk);
    #1 chk("irq_before_match", 64'(irq), 64'h0);
    @(posedge clk);
    #1 chk("irq_match", 64'(irq), 64'h1);
    bus_rd(8'h14, rd_data); chk("status_match", 64'(rd_data), 64'h5);
    bus_wr(8'h14, 32'h1);
    chk("irq_after_w1c", 64'(irq), 64'h0);
    bus_rd(8'h14, rd_data); chk("status_w1c", 64'(rd_data), 64'h4);
    bus_rd(8'h0C, rd_data); chk("cmp_rd", 64'(rd_data), 64'h5);

    // Counter wrap and freeze
    bus_wr(8'h08, 32'hFFFF_FFFF);
    bus_rd(8'h08, rd_data); chk("count_load", 64'(rd_data), 64'hFFFF_FFFF);
    bus_rd(8'h08, rd_data); chk("count_wrap", 64'(rd_data), 64'h0);
    bus_wr(8'h10, 32'h0);
    bus_wr(8'h14, 32'h1);
    bus_rd(8'h08, rd_data); chk("count_frozen", 64'(rd_data), 64'h2);

    // W1C on the same edge as a match: set wins
    bus_wr(8'h08, 32'd0);
    bus_wr(8'h10, 32'h1);
    repeat (5) @(posedge clk);
    bus_wr(8'h14, 32'h1);
    bus_rd(8'h14, rd_data); chk("w1c_collision", 64'(rd_data), 64'h5);
    bus_wr(8'h10, 32'h0);
    bus_wr(8'h14, 32'h1);
    bus_rd(8'h14, rd_data); chk("status_clean", 64'(rd_data), 64'h4);

    // CTRL readback and tx-empty interrupt
    bus_wr(8'h10, 32'hFFFF_FFF4);
    bus_rd(8'h10, rd_data); chk("ctrl_rd", 64'(rd_data), 64'h4);
    chk("irq_txempty", 64'(irq), 64'h1);
    bus_wr(8'h10, 32'h0);
    chk("irq_txempty_off", 64'(irq), 64'h0);

    // Single frame 0xA5 with busy tracking
    tx_push(8'hA5, 1'b1);
    bus_rd(8'h14, rd_data); chk("status_queued", 64'(rd_data), 64'h100);
    busy_all = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus_rd(8'h14, rd_data);
      busy_all &= rd_data[3];
    end
    chk("busy_during_frame", 64'(busy_all), 64'h1);
    bus_rd(8'h14, rd_data); chk("status_after_frame", 64'(rd_data), 64'h4);
    wait_frames(1, 50);

    // Overflow: six pushes back to back, sixth dropped
    for (int i = 1; i <= 6; i++) tx_push(8'(i * 8'h11), i != 6);
    bus_rd(8'h14, rd_data); chk("status_overflow", 64'(rd_data), 64'h41A);
    wait_frames(6, 400);
    bus_rd(8'h14, rd_data); chk("status_ovf_drained", 64'(rd_data), 64'h14);
    bus_wr(8'h14, 32'h10);
    bus_rd(8'h14, rd_data); chk("status_ovf_cleared", 64'(rd_data), 64'h4);

    // Push on the pop edge with two bytes queued
    tx_push(8'hC1, 1'b1);
    tx_push(8'hC2, 1'b1);
    tx_push(8'hC3, 1'b1);
    repeat (39) @(posedge clk);
    tx_push(8'hC4, 1'b1);
    bus_rd(8'h14, rd_data); chk("push_pop_count", 64'(rd_data), 64'h208);
    wait_frames(10, 300);

    // Reset during data bit 3
    bus_wr(8'h00, 32'h77);
    bus_wr(8'h10, 32'h4);
    tx_push(8'hE7, 1'b1);
    tx_push(8'h18, 1'b1);
    repeat (16) @(posedge clk);
    @(negedge clk) resetb = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_uart_tx", 64'(uart_tx), 64'h1);
    chk("midrst_gpio_out", 64'(gpio_out), 64'h0);
    chk("midrst_irq", 64'(irq), 64'h0);
    exp_q.delete();
    @(negedge clk) resetb = 1'b1;
    bus_rd(8'h14, rd_data); chk("midrst_status", 64'(rd_data), 64'h4);
    bus_rd(8'h10, rd_data); chk("midrst_ctrl", 64'(rd_data), 64'h0);
    f0 = frames;
    line_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) line_low = 1'b1;
    end
    chk("no_frame_after_reset", 64'(line_low), 64'h0);
    chk("frames_after_reset", 64'(frames), 64'(f0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Responder at the far end of the MMU I/O port, which covers byte range 0x80000000-0x800000FF.
- Decodes io_addr/io_en/io_we/io_data_write and returns io_data_read.
- Contains a GPIO block, a 32-bit timer with compare and a sticky match flag, and a TX FIFO feeding an 8N1 UART transmitter.
- Raises one level interrupt to the core.

Parameters:
GPIO_WIDTH, 8, width of gpio_in/gpio_out (1..32)
FIFO_DEPTH_LOG, 2, log2 of TX FIFO depth (depth 4)
CLKS_PER_BIT, 16, clocks per UART bit (>=2)

Ports:
clk  input  1  clock
resetb  input  1  reset, synchronous, active-low
io_addr  input  8  byte offset within I/O space; [7:2] selects register, [1:0] ignored
io_en  input  1  access valid this cycle
io_we  input  1  write strobe, qualified by io_en
io_data_write  input  32  write data, already lane-shifted by MMU
io_data_read  output  32  read data, combinational
gpio_in  input  GPIO_WIDTH  asynchronous inputs
gpio_out  output  GPIO_WIDTH  registered outputs
uart_tx  output  1  serial line, idle high
irq  output  1  level interrupt

Behaviour:
- Bus timing:
  - Read: io_data_read is a pure combinational function of io_addr and register state in the cycle io_en=1. The MMU samples it in that same cycle.
  - io_en=0 -> io_data_read=0.
  - Reads have no side effects.
  - Write: takes effect on the clk edge ending a cycle with io_en&io_we.
  - No byte enables. Every write is a full 32-bit write of io_data_write.
- Register map (offset: name, access):
  - 0x00 GPIO_OUT RW: [GPIO_WIDTH-1:0]; upper bits read 0.
  - 0x04 GPIO_IN RO: gpio_in after a 2-flop synchroniser.
  - 0x08 TIMER_COUNT RW: write loads value. Write wins over increment.
  - 0x0C TIMER_CMP RW.
  - 0x10 CTRL RW: bit0 timer_en, bit1 irq_timer_en, bit2 irq_txempty_en; other bits read 0.
  - 0x14 STATUS:
    - bit0 match (W1C); bit4 overflow (W1C).
    - bit1 fifo_full, bit2 fifo_empty, bit3 tx_busy (RO).
    - [15:8] fifo count (RO).
  - 0x18 TX_DATA WO: write pushes io_data_write[7:0]; reads 0.
  - Unmapped offsets: read 0, writes ignored.
- Timer:
  - When timer_en=1, count increments by 1 each cycle and wraps 0xFFFFFFFF->0.
  - On an edge where timer_en=1 and count==cmp, match is set.
  - Same-cycle set and W1C: set wins.
- TX FIFO:
  - Push on a TX_DATA write.
  - Full is evaluated before the edge. A push while full is dropped and sets overflow, even if a pop occurs that cycle.
  - A simultaneous push and pop (not full) leaves count unchanged.
  - Pointers wrap modulo depth.
- UART FSM, states IDLE/START/DATA/STOP; baud counter reloads CLKS_PER_BIT-1.
  - IDLE, FIFO non-empty: pop on the edge, load shifter, enter START. uart_tx=0 from that edge.
  - START: after CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles -> STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles -> IDLE.
  - Back-to-back frames are separated by exactly 1 idle-high cycle (frame period 10*CLKS_PER_BIT+1).
  - tx_busy = (state!=IDLE).
- irq = (match&irq_timer_en) | (fifo_empty&~tx_busy&irq_txempty_en); combinational from registers.
- Reset, on an edge with resetb=0:
  - gpio_out=0, count=0, cmp=0, ctrl=0, match=0, overflow=0.
  - FIFO emptied, state IDLE, uart_tx=1, synchroniser flops=0.
  - irq=0 follows.
- Reset mid-frame aborts the frame: uart_tx is 1 after the reset edge, and no partial byte is resumed.

Test Plan:
- GPIO: write 0x000000A5 to 0x00 -> gpio_out=0xA5 after that edge. Drive gpio_in=0x3C -> read 0x04 returns 0x3C from the third cycle on. Read 0x40 returns 0.
- Timer: write cmp=5, count=0, ctrl=0x3 -> match=1 and irq=1 after the edge where count==5. W1C STATUS=0x1 clears both. Write count=0xFFFFFFFF -> next cycle count=0.
- UART frame, CLKS_PER_BIT=4: write 0xA5 to 0x18 -> uart_tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles). tx_busy high throughout, low after.
- Overflow, CLKS_PER_BIT=4: 6 TX_DATA writes on consecutive cycles -> first byte popped immediately, FIFO full after the 5th, 6th dropped, STATUS bit4=1. Exactly 5 frames are sent, each with a 1-cycle gap.
- Collision: W1C of match on the same edge that count==cmp -> match remains 1. Push on the same edge as a pop with FIFO at 2 -> count stays 2.
- Reset during DATA bit 3 -> uart_tx=1, fifo_empty=1, gpio_out=0, irq=0 after the reset edge. No further frame without a new write.
